apb_slave_regs16: RTL and testbench

APB completer (slave) that answers the transfers an APB requester drives on the pclock16/preset16 bus. It holds a small word-addressed register bank. Wait states are configurable. It returns pslverr16 on illegal accesses. It sits behind one psel16 bit of the APB bus: the bench model of a peripheral, and the RTL endpoint for UVC self-checks.

---
 rtl/apb_slave_regs16_pkg.sv | 23 ++
 rtl/apb_slave_regs16_if.sv | 25 ++
 rtl/apb_slave_regs16.sv | 125 ++++++++++++
 tb/tb_apb_slave_regs16.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_regs16_pkg.sv
// rtl/apb_slave_regs16_pkg.sv - shared types, constants and decode helper for the APB register completer
package apb_slave_pkg16;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam int ADDR_LSB16 = 2;
    localparam int MAX_WAIT16 = 15;

    // Misaligned, beyond the bank, or a write aimed at the read-only status word.
    function automatic logic decode_err16(
        input logic [1:0] byte_off,
        input logic       out_of_range,
        input logic       is_write,
        input logic [3:0] idx,
        input logic [3:0] ro_idx
    );
        return (byte_off != 2'b00) || out_of_range || (is_write && (idx == ro_idx));
    endfunction

endpackage

// File: rtl/apb_slave_regs16_if.sv
// rtl/apb_slave_regs16_if.sv - APB bus signals seen by one completer select line
interface apb_slave_regs16_if #(
    parameter int PADDR_WIDTH16  = 32,
    parameter int PWDATA_WIDTH16 = 32,
    parameter int PRDATA_WIDTH16 = 32
);
    logic [PADDR_WIDTH16-1:0]  paddr16;
    logic                      prwd16;
    logic [PWDATA_WIDTH16-1:0] pwdata16;
    logic                      penable16;
    logic                      psel16;
    logic [PRDATA_WIDTH16-1:0] prdata16;
    logic                      pslverr16;
    logic                      pready16;

    modport master (
        output paddr16, prwd16, pwdata16, penable16, psel16,
        input  prdata16, pslverr16, pready16
    );

    modport slave (
        input  paddr16, prwd16, pwdata16, penable16, psel16,
        output prdata16, pslverr16, pready16
    );
endinterface

// File: rtl/apb_slave_regs16.sv
// rtl/apb_slave_regs16.sv - APB completer with a word-addressed register bank and configurable wait states
module apb_slave_regs16
    import apb_slave_pkg16::*;
#(
    parameter int PADDR_WIDTH16  = 32,
    parameter int PWDATA_WIDTH16 = 32,
    parameter int PRDATA_WIDTH16 = 32,
    parameter int NUM_REGS16     = 8,
    parameter int WAIT_STATES16  = 0
) (
    input  logic                                     pclock16,
    input  logic                                     preset16,
    apb_slave_regs16_if.slave                        bus,
    input  logic [PRDATA_WIDTH16-1:0]                status_in16,
    output logic [(NUM_REGS16-1)*PWDATA_WIDTH16-1:0] regs_out16
);

    localparam int                     NUM_RW     = NUM_REGS16 - 1;
    localparam logic [3:0]             RO_IDX     = 4'(NUM_REGS16 - 1);
    localparam logic [3:0]             WAIT_LOAD  = 4'(WAIT_STATES16);
    localparam logic [PADDR_WIDTH16-1:0] ADDR_LIMIT = PADDR_WIDTH16'(NUM_REGS16 * 4);

    if (PRDATA_WIDTH16 != PWDATA_WIDTH16) begin : g_bad_width
        $error("PRDATA_WIDTH16 must equal PWDATA_WIDTH16");
    end
    if (WAIT_STATES16 < 0 || WAIT_STATES16 > MAX_WAIT16) begin : g_bad_wait
        $error("WAIT_STATES16 out of range");
    end
    if (NUM_REGS16 < 2 || NUM_REGS16 > 16) begin : g_bad_regs
        $error("NUM_REGS16 out of range");
    end

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [3:0]                idx_q;
    logic                      write_q;
    logic                      err_q;
    logic                      load;
    logic                      commit;
    logic                      ready;
    logic [PWDATA_WIDTH16-1:0] regs_q [NUM_RW];
    logic [PWDATA_WIDTH16-1:0] rd_word;
    logic [3:0]                dec_idx;
    logic                      dec_err;

    assign dec_idx = bus.paddr16[ADDR_LSB16 +: 4];
    assign dec_err = decode_err16(bus.paddr16[1:0], bus.paddr16 >= ADDR_LIMIT,
                                  bus.prwd16, dec_idx, RO_IDX);

    always_ff @(posedge pclock16 or negedge preset16) begin
        if (!preset16) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_RW; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                idx_q   <= dec_idx;
                write_q <= bus.prwd16;
                err_q   <= dec_err;
            end
            for (int i = 0; i < NUM_RW; i++) begin
                if (commit && idx_q == 4'(i)) regs_q[i] <= bus.pwdata16;
            end
        end
    end

    // Losing psel mid-access is an abort: no commit, no response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.psel16 && !bus.penable16) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LOAD;
                    load    = 1'b1;
                end
            end
            ACCESS: begin
                if (!bus.psel16) begin
                    state_d = IDLE;
                end else if (bus.penable16) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        commit  = write_q && !err_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        if (idx_q == RO_IDX) begin
            rd_word = status_in16;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (idx_q == 4'(i)) rd_word = regs_q[i];
            end
        end
    end

    assign ready         = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign bus.pready16  = ready;
    assign bus.pslverr16 = ready && err_q;
    assign bus.prdata16  = (ready && !write_q && !err_q) ? rd_word : '0;

    always_comb begin
        regs_out16 = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            regs_out16[i*PWDATA_WIDTH16 +: PWDATA_WIDTH16] = regs_q[i];
        end
    end

endmodule

// File: tb/tb_apb_slave_regs16.sv
// tb/tb_apb_slave_regs16.sv - bench for apb_slave_regs16 with a zero-wait and a three-wait instance
module tb_apb_slave_regs16;

    localparam int NREG = 8;
    localparam int RW_BITS = (NREG - 1) * 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        penable = 1'b0;
    logic        psel0 = 1'b0;
    logic        psel1 = 1'b0;
    logic [31:0] status = '0;
    logic [RW_BITS-1:0] regs_out0, regs_out1;

    apb_slave_regs16_if bus0 ();
    apb_slave_regs16_if bus1 ();

    assign bus0.paddr16   = paddr;
    assign bus0.prwd16    = pwrite;
    assign bus0.pwdata16  = pwdata;
    assign bus0.penable16 = penable;
    assign bus0.psel16    = psel0;
    assign bus1.paddr16   = paddr;
    assign bus1.prwd16    = pwrite;
    assign bus1.pwdata16  = pwdata;
    assign bus1.penable16 = penable;
    assign bus1.psel16    = psel1;

    apb_slave_regs16 #(.NUM_REGS16(NREG), .WAIT_STATES16(0)) dut0 (
        .pclock16(clk), .preset16(rst_n), .bus(bus0.slave),
        .status_in16(status), .regs_out16(regs_out0)
    );
    apb_slave_regs16 #(.NUM_REGS16(NREG), .WAIT_STATES16(3)) dut1 (
        .pclock16(clk), .preset16(rst_n), .bus(bus1.slave),
        .status_in16(status), .regs_out16(regs_out1)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] model [2][NREG];

    typedef struct {
        int          sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] stat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [RW_BITS-1:0] act, input logic [RW_BITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 1) ? bus1.pready16 : bus0.pready16;
    endfunction
    function automatic logic [32:0] resp(input int sel);
        return (sel == 1) ? {bus1.pslverr16, bus1.prdata16} : {bus0.pslverr16, bus0.prdata16};
    endfunction
    function automatic logic [RW_BITS-1:0] dut_regs(input int sel);
        return (sel == 1) ? regs_out1 : regs_out0;
    endfunction
    function automatic logic [RW_BITS-1:0] model_regs(input int sel);
        logic [RW_BITS-1:0] v;
        for (int i = 0; i < NREG - 1; i++) v[i*32 +: 32] = model[sel][i];
        return v;
    endfunction

    // Reference: legal only when word-aligned, inside the bank, and not writing the status word.
    task automatic model_xfer(input int sel, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, output logic [31:0] rdata, output logic err);
        int idx;
        idx = int'(addr / 4);
        err = (addr % 4 != 0) || (addr >= NREG * 4) || (wr && idx == NREG - 1);
        rdata = '0;
        if (!err) begin
            if (wr) model[sel][idx] = data;
            else if (idx == NREG - 1) rdata = status;
            else rdata = model[sel][idx];
        end
    endtask

    task automatic xfer(input int sel, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic err, output int waits);
        @(negedge clk);
        paddr = addr; pwrite = wr; pwdata = data; penable = 1'b0;
        psel0 = (sel == 0); psel1 = (sel == 1);
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        while (!rdy(sel) && waits < 40) begin
            check("resp_zero_before_ready", {{(RW_BITS-33){1'b0}}, resp(sel)}, '0);
            @(negedge clk);
            waits++;
        end
        {err, rdata} = resp(sel);
        @(negedge clk);
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    endtask

    task automatic do_xfer(input string name, input int sel, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, output logic [31:0] rdata, output logic err, output int waits);
        logic [31:0] exp_rdata;
        logic        exp_err;
        model_xfer(sel, wr, addr, data, exp_rdata, exp_err);
        xfer(sel, wr, addr, data, rdata, err, waits);
        check({name, "_waits"}, RW_BITS'(waits), RW_BITS'((sel == 1) ? 3 : 0));
        check({name, "_prdata"}, RW_BITS'(rdata), RW_BITS'(exp_rdata));
        check({name, "_pslverr"}, RW_BITS'(err), RW_BITS'(exp_err));
        check({name, "_regs_out"}, dut_regs(sel), model_regs(sel));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          wt;
        logic [31:0] keep;

        for (int s = 0; s < 2; s++) for (int i = 0; i < NREG; i++) model[s][i] = '0;

        #2;
        check("reset_pready", RW_BITS'(bus0.pready16), '0);
        check("reset_resp", RW_BITS'({bus1.pslverr16, bus1.prdata16}), '0);
        check("reset_regs", regs_out0 | regs_out1, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{0, 1'b1, 32'h4,  32'hA5A5_0001, 32'h0,         32'h0,         1'b0, 0});
        vecs.push_back('{0, 1'b0, 32'h4,  32'h0,         32'h0,         32'hA5A5_0001, 1'b0, 0});
        vecs.push_back('{1, 1'b0, 32'h0,  32'h0,         32'h0,         32'h0,         1'b0, 3});
        vecs.push_back('{0, 1'b1, 32'h1C, 32'hCAFE_F00D, 32'h0,         32'h0,         1'b1, 0});
        vecs.push_back('{0, 1'b0, 32'h20, 32'h0,         32'h0,         32'h0,         1'b1, 0});
        vecs.push_back('{0, 1'b1, 32'h6,  32'h0BAD_BEEF, 32'h0,         32'h0,         1'b1, 0});
        vecs.push_back('{0, 1'b0, 32'h1C, 32'h0,         32'h1234_5678, 32'h1234_5678, 1'b0, 0});
        vecs.push_back('{0, 1'b0, 32'h4,  32'h0,         32'h0,         32'hA5A5_0001, 1'b0, 0});
        vecs.push_back('{1, 1'b1, 32'h8,  32'h1111_2222, 32'h0,         32'h0,         1'b0, 3});

        foreach (vecs[k]) begin
            status = vecs[k].stat;
            do_xfer($sformatf("vec%0d", k), vecs[k].sel, vecs[k].wr, vecs[k].addr, vecs[k].data, rd, er, wt);
            check($sformatf("vec%0d_tbl_prdata", k), RW_BITS'(rd), RW_BITS'(vecs[k].exp_rdata));
            check($sformatf("vec%0d_tbl_pslverr", k), RW_BITS'(er), RW_BITS'(vecs[k].exp_err));
            check($sformatf("vec%0d_tbl_waits", k), RW_BITS'(wt), RW_BITS'(vecs[k].exp_waits));
        end
        check("word1_after_write", RW_BITS'(regs_out0[32 +: 32]), RW_BITS'(32'hA5A5_0001));

        // Abort: psel drops in the second wait cycle of a write to 0x8.
        keep = regs_out1[64 +: 32];
        @(negedge clk);
        paddr = 32'h8; pwrite = 1'b1; pwdata = 32'hDEAD_DEAD; penable = 1'b0; psel1 = 1'b1;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        psel1 = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_pready", RW_BITS'(bus1.pready16), '0);
        check("abort_word2", RW_BITS'(regs_out1[64 +: 32]), RW_BITS'(keep));
        do_xfer("abort_readback", 1, 1'b0, 32'h8, 32'h0, rd, er, wt);
        check("abort_readback_val", RW_BITS'(rd), RW_BITS'(32'h1111_2222));

        // Access phase without a setup phase is ignored.
        @(negedge clk);
        paddr = 32'h4; pwrite = 1'b0; psel0 = 1'b1; penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_setup_pready", RW_BITS'(bus0.pready16), '0);
        end
        psel0 = 1'b0; penable = 1'b0;

        for (int n = 0; n < 60; n++) begin
            int          sel;
            logic [31:0] a;
            sel = int'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       a = 32'($urandom_range(0, NREG * 4 - 1));
                1:       a = 32'(NREG * 4) + 32'($urandom_range(0, 15) * 4);
                2:       a = 32'h1C;
                default: a = 32'($urandom_range(0, NREG - 1) * 4);
            endcase
            status = $urandom;
            do_xfer($sformatf("rnd%0d", n), sel, 1'($urandom_range(0, 1)), a, $urandom, rd, er, wt);
        end

        // Reset while a zero-wait read of 0x0 holds valid data.
        do_xfer("pre_reset_write", 0, 1'b1, 32'h0, 32'hFFFF_FFFF, rd, er, wt);
        @(negedge clk);
        paddr = 32'h0; pwrite = 1'b0; penable = 1'b0; psel0 = 1'b1;
        @(negedge clk);
        penable = 1'b1;
        check("pre_reset_prdata", RW_BITS'(bus0.prdata16), RW_BITS'(32'hFFFF_FFFF));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_resp", RW_BITS'({bus0.pready16, bus0.pslverr16, bus0.prdata16}), '0);
        check("async_reset_regs0", regs_out0, '0);
        check("async_reset_regs1", regs_out1, '0);
        for (int s = 0; s < 2; s++) for (int i = 0; i < NREG; i++) model[s][i] = '0;
        @(negedge clk);
        psel0 = 1'b0; penable = 1'b0;
        rst_n = 1'b1;
        do_xfer("post_reset_read", 0, 1'b0, 32'h0, 32'h0, rd, er, wt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
